// File: rtl/accelerator_tensor_fixed_multiplier_scheduler_pkg.sv
// Shared types/constants for the tensor multiplier scheduler.
// FSM state encoding, data constants and flag levels.
package accelerator_tensor_pkg;

  localparam int PKG_DATA_SIZE = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_ENDER  = 3'd4
  } state_t;

  localparam logic [PKG_DATA_SIZE-1:0] ZERO_DATA = '0;
  localparam logic [PKG_DATA_SIZE-1:0] ONE_DATA  = 64'd1;

  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;

endpackage

// File: rtl/accelerator_tensor_fixed_multiplier_scheduler_if.sv
// Bus between tensor control, scheduler and vector multiplier.
// master: control + vector unit side; slave: the scheduler.
interface accelerator_tensor_fixed_multiplier_scheduler_if #(
  parameter int DATA_SIZE = 64
);

  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] SIZE_K_IN;
  logic                 DATA_IN_VALID;
  logic                 DATA_IN_ACCEPT;
  logic [DATA_SIZE-1:0] DATA_A_IN;
  logic [DATA_SIZE-1:0] DATA_B_IN;
  logic                 VECTOR_START;
  logic [DATA_SIZE-1:0] VECTOR_SIZE;
  logic                 VECTOR_DATA_A_ENABLE;
  logic                 VECTOR_DATA_B_ENABLE;
  logic [DATA_SIZE-1:0] VECTOR_DATA_A;
  logic [DATA_SIZE-1:0] VECTOR_DATA_B;
  logic                 VECTOR_READY;
  logic                 VECTOR_DATA_OUT_ENABLE;
  logic [DATA_SIZE-1:0] VECTOR_DATA_OUT;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 DATA_OUT_K_ENABLE;

  modport master (
    output START, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN,
    output DATA_IN_VALID, DATA_A_IN, DATA_B_IN,
    output VECTOR_READY, VECTOR_DATA_OUT_ENABLE,
    output VECTOR_DATA_OUT,
    input  READY, DATA_IN_ACCEPT, VECTOR_START,
    input  VECTOR_SIZE, VECTOR_DATA_A_ENABLE,
    input  VECTOR_DATA_B_ENABLE, VECTOR_DATA_A,
    input  VECTOR_DATA_B, DATA_OUT,
    input  DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
    input  DATA_OUT_K_ENABLE
  );

  modport slave (
    input  START, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN,
    input  DATA_IN_VALID, DATA_A_IN, DATA_B_IN,
    input  VECTOR_READY, VECTOR_DATA_OUT_ENABLE,
    input  VECTOR_DATA_OUT,
    output READY, DATA_IN_ACCEPT, VECTOR_START,
    output VECTOR_SIZE, VECTOR_DATA_A_ENABLE,
    output VECTOR_DATA_B_ENABLE, VECTOR_DATA_A,
    output VECTOR_DATA_B, DATA_OUT,
    output DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
    output DATA_OUT_K_ENABLE
  );

endinterface

// File: rtl/accelerator_tensor_fixed_multiplier_scheduler_index_counter.sv
// Nested i/j row counter: j wraps into i on each row step.
// Ports: clr_i/step_i control, sizes in, j_last_o/last_o flags.
module accelerator_tensor_index_counter #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic [DATA_SIZE-1:0] size_i_i,
  input  logic [DATA_SIZE-1:0] size_j_i,
  output logic                 j_last_o,
  output logic                 last_o
);
  import accelerator_tensor_pkg::*;

  typedef logic [DATA_SIZE-1:0] word_t;

  localparam word_t ZERO = word_t'(ZERO_DATA);
  localparam word_t ONE  = word_t'(ONE_DATA);

  word_t i_q, i_d;
  word_t j_q, j_d;
  logic  i_last;

  assign j_last_o = (j_q == size_j_i - ONE);
  assign i_last   = (i_q == size_i_i - ONE);
  assign last_o   = i_last && j_last_o;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    unique case (1'b1)
      clr_i: begin
        i_d = ZERO;
        j_d = ZERO;
      end
      step_i: begin
        if (!j_last_o) begin
          j_d = j_q + ONE;
        end else begin
          j_d = ZERO;
          if (!i_last) i_d = i_q + ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= ZERO;
      j_q <= ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/accelerator_tensor_fixed_multiplier_scheduler.sv
// Walks an I x J x K tensor as rows of K elements through a vector
// multiplier, tagging results with I/J/K boundary strobes.
module accelerator_tensor_fixed_multiplier_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input logic CLK,
  input logic RST,
  accelerator_tensor_fixed_multiplier_scheduler_if.slave bus
);
  import accelerator_tensor_pkg::*;

  typedef logic [DATA_SIZE-1:0]    word_t;
  typedef logic [CONTROL_SIZE-1:0] ctl_t;

  localparam word_t ZERO = word_t'(ZERO_DATA);
  localparam word_t ONE  = word_t'(ONE_DATA);

  localparam ctl_t ST_IDLE   = CONTROL_SIZE'(S_IDLE);
  localparam ctl_t ST_LAUNCH = CONTROL_SIZE'(S_LAUNCH);
  localparam ctl_t ST_FEED   = CONTROL_SIZE'(S_FEED);
  localparam ctl_t ST_DRAIN  = CONTROL_SIZE'(S_DRAIN);
  localparam ctl_t ST_ENDER  = CONTROL_SIZE'(S_ENDER);

  ctl_t  state_q, state_d;
  logic  st_idle, st_launch, st_feed;
  logic  st_drain, st_ender;

  word_t si_q, sj_q, sk_q;
  word_t kin_q, kout_q;
  word_t va_q, vb_q, dout_q;
  logic  ven_q, ken_q, jen_q, ien_q;
  logic  ready_q, ready_d;
  logic  seen_q;

  logic  vstart, accept;
  logic  ctr_clr, ctr_step;
  logic  zero_size, hs, last_in;
  logic  res_hs, res_last, row_done;
  logic  j_last, all_last;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_launch = (state_q == ST_LAUNCH);
  assign st_feed   = (state_q == ST_FEED);
  assign st_drain  = (state_q == ST_DRAIN);
  assign st_ender  = (state_q == ST_ENDER);

  assign zero_size = (bus.SIZE_I_IN == ZERO)
                  || (bus.SIZE_J_IN == ZERO)
                  || (bus.SIZE_K_IN == ZERO);

  assign hs      = accept && bus.DATA_IN_VALID;
  assign last_in = hs && (kin_q + ONE == sk_q);

  // Strobes beyond the row length are dropped.
  assign res_hs = (st_feed || st_drain)
               && bus.VECTOR_DATA_OUT_ENABLE
               && (kout_q < sk_q);
  assign res_last = (kout_q == sk_q - ONE);

  // seen_q remembers an early done; the live input covers
  // a done that arrives only once the row is drained.
  assign row_done = st_drain && (kout_q == sk_q)
                 && (seen_q || bus.VECTOR_READY);

  accelerator_tensor_index_counter #(
    .DATA_SIZE (DATA_SIZE)
  ) u_idx (
    .clk      (CLK),
    .rst_n    (RST),
    .clr_i    (ctr_clr),
    .step_i   (ctr_step),
    .size_i_i (si_q),
    .size_j_i (sj_q),
    .j_last_o (j_last),
    .last_o   (all_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: begin
        if (bus.START)
          state_d = zero_size ? ST_ENDER : ST_LAUNCH;
      end
      st_launch: state_d = ST_FEED;
      st_feed: begin
        if (last_in) state_d = ST_DRAIN;
      end
      st_drain: begin
        if (row_done)
          state_d = all_last ? ST_ENDER : ST_LAUNCH;
      end
      st_ender: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vstart   = st_launch;
    accept   = st_feed && (kin_q < sk_q);
    ctr_clr  = st_idle && bus.START;
    ctr_step = row_done && !all_last;
    ready_d  = st_ender;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      si_q    <= ZERO;
      sj_q    <= ZERO;
      sk_q    <= ZERO;
      kin_q   <= ZERO;
      kout_q  <= ZERO;
      seen_q  <= EMPTY;
      va_q    <= ZERO;
      vb_q    <= ZERO;
      ven_q   <= 1'b0;
      dout_q  <= ZERO;
      ken_q   <= 1'b0;
      jen_q   <= 1'b0;
      ien_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (ctr_clr) begin
        si_q <= bus.SIZE_I_IN;
        sj_q <= bus.SIZE_J_IN;
        sk_q <= bus.SIZE_K_IN;
      end

      if (ctr_clr || st_launch) kin_q <= ZERO;
      else if (hs)              kin_q <= kin_q + ONE;

      if (ctr_clr || st_launch) kout_q <= ZERO;
      else if (res_hs)          kout_q <= kout_q + ONE;

      if (ctr_clr || st_launch)
        seen_q <= EMPTY;
      else if ((st_feed || st_drain) && bus.VECTOR_READY)
        seen_q <= FULL;

      if (hs) begin
        va_q <= bus.DATA_A_IN;
        vb_q <= bus.DATA_B_IN;
      end
      ven_q <= hs;

      if (res_hs) dout_q <= bus.VECTOR_DATA_OUT;
      ken_q <= res_hs;
      jen_q <= res_hs && res_last;
      ien_q <= res_hs && res_last && j_last;

      ready_q <= ready_d;
    end
  end

  assign bus.READY                = ready_q;
  assign bus.DATA_IN_ACCEPT       = accept;
  assign bus.VECTOR_START         = vstart;
  assign bus.VECTOR_SIZE          = sk_q;
  assign bus.VECTOR_DATA_A_ENABLE = ven_q;
  assign bus.VECTOR_DATA_B_ENABLE = ven_q;
  assign bus.VECTOR_DATA_A        = va_q;
  assign bus.VECTOR_DATA_B        = vb_q;
  assign bus.DATA_OUT             = dout_q;
  assign bus.DATA_OUT_I_ENABLE    = ien_q;
  assign bus.DATA_OUT_J_ENABLE    = jen_q;
  assign bus.DATA_OUT_K_ENABLE    = ken_q;

endmodule
